piso_serial_tx: RTL and testbench

//   Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word from an

---
 rtl/piso_serial_tx.sv | 143 ++++++++++++++
 tb/tb_piso_serial_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: frames a WIDTH-bit word as start(0), data LSB first, stop(1).
// Latency: tx goes low the edge after accept; a frame is (WIDTH+2)*CLKS_PER_BIT enabled cycles, done pulses after stop.
// Backpressure: d_ready is low for the whole frame; d/d_valid are ignored until the block returns to IDLE.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous reset, active low
//   enable  - global advance enable; 0 freezes all state (done still clears)
//   d       - parallel word, latched on accept
//   d_valid - d holds a word to send
//   d_ready - block can accept a word this cycle
//   tx      - serial line, idles high
//   busy    - frame in progress
//   done    - one-cycle pulse after the stop bit completes
module piso_serial_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;
  logic             done_q, done_d;
  logic             cyc_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign cyc_end = (cyc_q == CYC_LAST);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    // done is a pulse: it clears on every edge, enabled or not
    done_d  = 1'b0;

    if (enable) begin
      case (state_q)
        IDLE: begin
          if (d_valid && rdy_q) begin
            state_d = START;
            shreg_d = d;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            rdy_d   = 1'b0;
            cyc_d   = '0;
            bit_d   = '0;
          end
        end
        START: begin
          if (cyc_end) begin
            // the shift register always presents the next data bit at [0]
            state_d = DATA;
            cyc_d   = '0;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        DATA: begin
          if (cyc_end) begin
            cyc_d = '0;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
              bit_d   = '0;
              tx_d    = 1'b1;
            end else begin
              bit_d   = bit_q + 1'b1;
              tx_d    = shreg_q[0];
              shreg_d = shreg_q >> 1;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        STOP: begin
          if (cyc_end) begin
            state_d = IDLE;
            cyc_d   = '0;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign d_ready = rdy_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx (WIDTH=4, CLKS_PER_BIT=4, clk period 10).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected tx is derived from the word and the count of enabled edges since accept.
module tb_piso_serial_tx;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] d;
  logic       d_valid;
  logic       d_ready;
  logic       tx;
  logic       busy;
  logic       done;

  int vectors = 0;
  int errors  = 0;

  piso_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, ".tx"},      tx,      1'b1);
    chk({tag, ".busy"},    busy,    1'b0);
    chk({tag, ".d_ready"}, d_ready, 1'b1);
    chk({tag, ".done"},    done,    exp_done);
  endtask

  // Called 1 unit after the accept edge. Applies nd/nvld immediately, optionally
  // drops enable for dis_len edges starting at the edge after sample dis_start,
  // checks every cycle of the frame and finally the done cycle.
  task automatic frame_chk(input string tag, input logic [3:0] w,
                           input logic [3:0] nd, input logic nvld,
                           input int dis_start, input int dis_len);
    logic [5:0] bits;
    int e;
    bits = {1'b1, w, 1'b0};
    e = 0;
    for (int n = 0; n < 24 + dis_len; n++) begin
      if (n == 0) begin
        d       = nd;
        d_valid = nvld;
      end
      chk($sformatf("%s.tx[%0d]", tag, n), tx, bits[e/4]);
      chk($sformatf("%s.busy[%0d]", tag, n), busy, 1'b1);
      chk($sformatf("%s.rdy[%0d]", tag, n), d_ready, 1'b0);
      chk($sformatf("%s.done[%0d]", tag, n), done, 1'b0);
      enable = !(n >= dis_start && n < dis_start + dis_len);
      step();
      if (enable) e++;
    end
    enable = 1'b1;
    chk_idle({tag, ".end"}, 1'b1);
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    d       = 4'b1001;
    d_valid = 1'b1;

    // 1: reset with d_valid high, no frame may start
    #1 rst = 1'b0;
    #1;
    chk_idle("rst.async", 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("rst.hold%0d", i), 1'b0);
    end
    d_valid = 1'b0;
    rst     = 1'b1;
    step();
    chk_idle("rst.released", 1'b0);

    // 2: single frame 1001, valid for one cycle
    d       = 4'b1001;
    d_valid = 1'b1;
    step();
    frame_chk("single", 4'b1001, 4'b1001, 1'b0, 0, 0);
    step();
    chk_idle("single.after", 1'b0);

    // 3: back-to-back 0101 then 1111 with valid held high
    d       = 4'b0101;
    d_valid = 1'b1;
    step();
    frame_chk("b2b.f1", 4'b0101, 4'b1111, 1'b1, 0, 0);
    step();
    frame_chk("b2b.f2", 4'b1111, 4'b1111, 1'b0, 0, 0);
    step();
    chk_idle("b2b.after", 1'b0);

    // 4: enable low for 10 edges while data bit 2 of 0111 is on the line
    d       = 4'b0111;
    d_valid = 1'b1;
    step();
    frame_chk("gate", 4'b0111, 4'b0111, 1'b0, 13, 10);
    // done clears on a disabled edge too
    enable = 1'b0;
    step();
    chk_idle("gate.done_clr", 1'b0);
    // enable low with d_valid high in IDLE: no accept
    d       = 4'b0011;
    d_valid = 1'b1;
    step();
    chk_idle("gate.noacc0", 1'b0);
    step();
    chk_idle("gate.noacc1", 1'b0);
    d_valid = 1'b0;
    enable  = 1'b1;
    step();
    chk_idle("gate.resume", 1'b0);

    // 5: reset during DATA of 1111 aborts at once, then a clean 0000 frame
    d       = 4'b1111;
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    for (int n = 0; n < 9; n++) begin
      chk($sformatf("abort.tx[%0d]", n), tx, (n < 4) ? 1'b0 : 1'b1);
      chk($sformatf("abort.busy[%0d]", n), busy, 1'b1);
      step();
    end
    #2 rst = 1'b0;
    #1;
    chk_idle("abort.async", 1'b0);
    step();
    chk_idle("abort.hold", 1'b0);
    rst = 1'b1;
    step();
    chk_idle("abort.nodone", 1'b0);
    d       = 4'b0000;
    d_valid = 1'b1;
    step();
    frame_chk("clean", 4'b0000, 4'b0000, 1'b0, 0, 0);
    step();

    // 6: d changes mid-frame, line still carries the latched word
    d       = 4'b1100;
    d_valid = 1'b1;
    step();
    frame_chk("ignore", 4'b1100, 4'b1010, 1'b0, 0, 0);
    step();
    chk_idle("ignore.after", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
